// File: rtl/axis_broadcaster_masked_if.sv
// Bundles the input stream and the replicated output streams of the masked broadcaster.
// The design uses the slave view; the driver of the input stream uses the master view.
interface axis_broadcaster_masked_if #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS    = 2
);
  logic                                  axis_i_tready;
  logic                                  axis_i_tvalid;
  logic                                  axis_i_tlast;
  logic [AXIS_BYTES*8-1:0]               axis_i_tdata;
  logic [AXIS_USER_BITS-1:0]             axis_i_tuser;
  logic [NUM_STREAMS-1:0]                axis_i_tdest_mask;
  logic [NUM_STREAMS-1:0]                axis_o_tready;
  logic [NUM_STREAMS-1:0]                axis_o_tvalid;
  logic [NUM_STREAMS-1:0]                axis_o_tlast;
  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]   axis_o_tdata;
  logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_o_tuser;

  modport slave (
    output axis_i_tready,
    input  axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_i_tuser, axis_i_tdest_mask,
    input  axis_o_tready,
    output axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tuser
  );

  modport master (
    input  axis_i_tready,
    output axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_i_tuser, axis_i_tdest_mask,
    output axis_o_tready,
    input  axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tuser
  );
endinterface

// File: rtl/axis_broadcaster_masked.sv
// Eager packet-level AXI-Stream fork: each beat is held once and handed to every output in
// the packet's destination mask independently; zero-mask packets are swallowed and counted.

// One output lane: remembers whether this output already took the current hold beat.
module axis_broadcaster_masked_lane (
  input  logic clk,
  input  logic sresetn,
  input  logic hold_valid,
  input  logic sel,
  input  logic clr,
  input  logic tready,
  output logic tvalid,
  output logic lane_done
);
  logic taken;

  assign tvalid    = sresetn & hold_valid & sel & ~taken;
  assign lane_done = ~sel | taken | tready;

  always_ff @(posedge clk) begin
    if (!sresetn)               taken <= 1'b0;
    else if (clr)               taken <= 1'b0;
    else if (tvalid && tready)  taken <= 1'b1;
  end
endmodule

module axis_broadcaster_masked #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS    = 2
) (
  input  logic                   clk,
  input  logic                   sresetn,
  axis_broadcaster_masked_if.slave axis,
  output logic [15:0]            drop_count
);
  localparam int W = AXIS_BYTES*8;

  logic                      hold_valid;
  logic [W-1:0]              hold_data;
  logic [AXIS_USER_BITS-1:0] hold_user;
  logic                      hold_last;
  logic [NUM_STREAMS-1:0]    hold_mask;
  logic [NUM_STREAMS-1:0]    pkt_mask;
  logic                      sof;
  logic [NUM_STREAMS-1:0]    beat_mask;
  logic [NUM_STREAMS-1:0]    lane_done;
  logic [NUM_STREAMS-1:0]    o_vld;
  logic                      done;
  logic                      accept;

  // The destination mask is only meaningful on the first beat; later beats reuse it.
  assign beat_mask = sof ? axis.axis_i_tdest_mask : pkt_mask;
  assign done      = hold_valid & (&lane_done);
  assign axis.axis_i_tready = sresetn & (~hold_valid | done);
  assign accept    = axis.axis_i_tvalid & axis.axis_i_tready;

  axis_broadcaster_masked_lane u_lane [NUM_STREAMS-1:0] (
    .clk        (clk),
    .sresetn    (sresetn),
    .hold_valid (hold_valid),
    .sel        (hold_mask),
    .clr        (accept | done),
    .tready     (axis.axis_o_tready),
    .tvalid     (o_vld),
    .lane_done  (lane_done)
  );

  assign axis.axis_o_tvalid = o_vld;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_out
    assign axis.axis_o_tdata[(i+1)*W-1 -: W]                           = hold_data;
    assign axis.axis_o_tuser[(i+1)*AXIS_USER_BITS-1 -: AXIS_USER_BITS] = hold_user;
    assign axis.axis_o_tlast[i]                                         = hold_last;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_user  <= '0;
      hold_last  <= 1'b0;
      hold_mask  <= '0;
      pkt_mask   <= '0;
      sof        <= 1'b1;
      drop_count <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= axis.axis_i_tdata;
      hold_user  <= axis.axis_i_tuser;
      hold_last  <= axis.axis_i_tlast;
      hold_mask  <= beat_mask;
      sof        <= axis.axis_i_tlast;
      if (sof) pkt_mask <= axis.axis_i_tdest_mask;
      if (axis.axis_i_tlast && beat_mask == '0 && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end else if (done) begin
      hold_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_broadcaster_masked.sv
// Directed bench for the masked broadcaster with per-output expected-beat queues.
module tb_axis_broadcaster_masked;
  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic [15:0] drop_count;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Expected entries are {tuser, tlast, tdata}.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always #5 clk = ~clk;

  axis_broadcaster_masked_if #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(3)) bus ();

  axis_broadcaster_masked #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(3)) dut (
    .clk        (clk),
    .sresetn    (sresetn),
    .axis       (bus.slave),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] m, input logic [9:0] v);
    if (m[0]) q0.push_back(v);
    if (m[1]) q1.push_back(v);
    if (m[2]) q2.push_back(v);
  endtask

  task automatic pop_cmp(input int lane, input logic [9:0] act);
    logic [9:0] exp;
    int sz;
    sz = (lane == 0) ? q0.size() : (lane == 1) ? q1.size() : q2.size();
    n_cmp++;
    if (sz == 0) begin
      n_bad++;
      $display("FAIL out%0d_unexpected: got beat 0x%0h expected no beat", lane, act);
    end else begin
      case (lane)
        0:       exp = q0.pop_front();
        1:       exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      if (act !== exp) begin
        n_bad++;
        $display("FAIL out%0d_beat: got 0x%0h expected 0x%0h", lane, act, exp);
      end
    end
  endtask

  // Monitor: a handshake is committed at the next rising edge, so sample mid-cycle.
  always @(negedge clk) begin
    if (sresetn) begin
      for (int i = 0; i < 3; i++)
        if (bus.axis_o_tvalid[i] && bus.axis_o_tready[i])
          pop_cmp(i, {bus.axis_o_tuser[i], bus.axis_o_tlast[i], bus.axis_o_tdata[i*8 +: 8]});
    end
  end

  // Presents one beat starting just after a rising edge; returns just after its accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic [2:0] m,
                           input logic [2:0] exp_m, inout int stalls);
    int waited;
    bus.axis_i_tvalid     = 1'b1;
    bus.axis_i_tdata      = d;
    bus.axis_i_tlast      = last;
    bus.axis_i_tuser      = d[0];
    bus.axis_i_tdest_mask = m;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.axis_i_tready) break;
      stalls++;
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    push(exp_m, {d[0], last, d});
    @(posedge clk); #1;
    bus.axis_i_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_q0_empty"}, q0.size(), 0);
    chk({name, "_q1_empty"}, q1.size(), 0);
    chk({name, "_q2_empty"}, q2.size(), 0);
  endtask

  initial begin
    int st;
    bus.axis_i_tvalid     = 1'b0;
    bus.axis_i_tlast      = 1'b0;
    bus.axis_i_tdata      = '0;
    bus.axis_i_tuser      = '0;
    bus.axis_i_tdest_mask = '0;
    bus.axis_o_tready     = 3'b111;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_i_tready", bus.axis_i_tready, 0);
    chk("rst_o_tvalid", bus.axis_o_tvalid, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge clk); #1;
    sresetn = 1'b1;
    @(posedge clk); #1;

    // All outputs, full rate.
    st = 0;
    for (int b = 0; b < 4; b++)
      send_beat(8'h10 + 8'(b), b == 3, 3'b111, 3'b111, st);
    chk("t1_no_stall", st, 0);
    drain("t1");

    // Output 2 lags: input must wait for it, output 0 drops tvalid after taking.
    bus.axis_o_tready     = 3'b001;
    bus.axis_i_tvalid     = 1'b1;
    bus.axis_i_tdata      = 8'h20;
    bus.axis_i_tuser      = 1'b0;
    bus.axis_i_tlast      = 1'b1;
    bus.axis_i_tdest_mask = 3'b101;
    @(negedge clk);
    chk("t2_c0_i_tready", bus.axis_i_tready, 1);
    push(3'b101, {1'b0, 1'b1, 8'h20});
    @(posedge clk); #1;
    bus.axis_i_tdata = 8'h21;
    bus.axis_i_tuser = 1'b1;
    @(negedge clk);
    chk("t2_c1_o_tvalid", bus.axis_o_tvalid, 3'b101);
    chk("t2_c1_i_tready", bus.axis_i_tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_c2_o_tvalid", bus.axis_o_tvalid, 3'b100);
    chk("t2_c2_i_tready", bus.axis_i_tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_c3_o_tvalid", bus.axis_o_tvalid, 3'b100);
    chk("t2_c3_i_tready", bus.axis_i_tready, 0);
    @(posedge clk); #1;
    bus.axis_o_tready = 3'b111;
    @(negedge clk);
    chk("t2_c4_o_tvalid", bus.axis_o_tvalid, 3'b100);
    chk("t2_c4_i_tready", bus.axis_i_tready, 1);
    push(3'b101, {1'b1, 1'b1, 8'h21});
    @(posedge clk); #1;
    bus.axis_i_tvalid = 1'b0;
    @(negedge clk);
    chk("t2_c5_o_tvalid", bus.axis_o_tvalid, 3'b101);
    drain("t2");

    // Mask taken from the first beat only.
    st = 0;
    send_beat(8'h30, 1'b0, 3'b010, 3'b010, st);
    send_beat(8'h31, 1'b1, 3'b111, 3'b010, st);
    drain("t3");

    // Zero-mask packet is discarded at full rate, then a normal packet.
    chk("t4_drop_before", drop_count, 0);
    st = 0;
    for (int b = 0; b < 5; b++)
      send_beat(8'h40 + 8'(b), b == 4, (b == 0) ? 3'b000 : 3'b111, 3'b000, st);
    chk("t4_no_stall", st, 0);
    chk("t4_drop_after", drop_count, 1);
    send_beat(8'h50, 1'b1, 3'b001, 3'b001, st);
    drain("t4");

    // Reset while output 1 is stalled mid-packet.
    bus.axis_o_tready = 3'b101;
    st = 0;
    send_beat(8'h60, 1'b0, 3'b010, 3'b000, st);
    @(negedge clk);
    chk("t6_stalled_o_tvalid", bus.axis_o_tvalid, 3'b010);
    @(posedge clk); #1;
    sresetn = 1'b0;
    @(negedge clk);
    chk("t6_rst_o_tvalid", bus.axis_o_tvalid, 0);
    chk("t6_rst_i_tready", bus.axis_i_tready, 0);
    @(posedge clk); #1;
    sresetn = 1'b1;
    bus.axis_o_tready = 3'b111;
    chk("t6_rst_drop", drop_count, 0);
    send_beat(8'h61, 1'b1, 3'b100, 3'b100, st);
    drain("t6");

    // Saturation of the drop counter over 0x10000 zero-mask single-beat packets.
    bus.axis_i_tvalid     = 1'b1;
    bus.axis_i_tlast      = 1'b1;
    bus.axis_i_tdata      = 8'h77;
    bus.axis_i_tdest_mask = 3'b000;
    repeat (65534) @(posedge clk);
    #1;
    chk("t5_drop_fffe", drop_count, 16'hFFFE);
    repeat (2) @(posedge clk);
    #1;
    bus.axis_i_tvalid = 1'b0;
    chk("t5_drop_sat", drop_count, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_drop_hold", drop_count, 16'hFFFF);
    drain("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
